conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (legal range 3..64).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels (legal range 3..64).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning width of the SRAM and output address buses.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 i_clk  input  1  clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_start  input  1  one-cycle request to process one frame.
REQ-008 i_kernel  input  144  two-channel 3x3 kernel, 8-bit Q4 signed elements, sampled when i_start is accepted.
REQ-009 o_busy  output  1  frame in progress.
REQ-010 o_done  output  1  one-cycle pulse after the last output handshake.
REQ-011 o_rd_en  output  1  SRAM read strobe.
REQ-012 o_rd_addr  output  ADDR_W  pixel address, row*IMG_W+col.
REQ-013 i_rd_data  input  16  returned pixel, ch0 in [15:8] and ch1 in [7:0], valid exactly 1 cycle after o_rd_en.
REQ-014 o_pe_image  output  144  window to the PE.
REQ-015 o_pe_kernel  output  144  kernel to the PE.
REQ-016 i_pe_result  input  16  combinational PE result.
REQ-017 o_out_valid  output  1  output pixel valid.
REQ-018 o_out_data  output  16  output pixel.
REQ-019 o_out_addr  output  ADDR_W  output index, oy*(IMG_W-2)+ox.
REQ-020 i_out_ready  input  1  downstream accept.

Function
REQ-021 FSM states: IDLE, LOAD, WAIT, CALC, OUT, DONE.
REQ-022 IDLE->LOAD when i_start=1. On that transition: latch i_kernel, set ox=oy=0, k=0.
REQ-023 i_start SHALL be ignored in every state other than IDLE.
REQ-024 LOAD: issue 9 consecutive reads, one per cycle, with o_rd_en=1 and o_rd_addr=(oy+k/3)*IMG_W+(ox+k%3) for k=0..8 in raster order.
REQ-025 LOAD->WAIT after the k=8 read is issued.
REQ-026 Read data for element k SHALL be captured the cycle after its read: ch0 into o_pe_image[143-8k -: 8] and ch1 into o_pe_image[71-8k -: 8].
REQ-027 WAIT captures element 8, then goes to CALC.
REQ-028 CALC registers i_pe_result into o_out_data and the output index into o_out_addr, then goes to OUT.
REQ-029 OUT: o_out_valid=1. o_out_data and o_out_addr SHALL be held stable until i_out_ready=1.
REQ-030 Output handshake completes on a cycle with valid and ready both 1. Latency from the first LOAD cycle to o_out_valid is 11 cycles; minimum throughput is 12 cycles per pixel.
REQ-031 After the handshake the window SHALL advance: ox++; when ox wraps from IMG_W-3 to 0, oy++.
REQ-032 If the handshake was for the last pixel (ox=IMG_W-3, oy=IMG_H-3), go to DONE; otherwise go to LOAD.
REQ-033 DONE SHALL assert o_done for exactly 1 cycle, then go to IDLE.
REQ-034 o_busy=1 in every state except IDLE.
REQ-035 o_pe_kernel SHALL equal the kernel latched at start for the whole frame.
REQ-036 A frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) outputs in raster order.
REQ-037 o_rd_en=0 outside LOAD.
REQ-038 o_out_valid=0 outside OUT.

Reset
REQ-039 Reset assertion at any time, including mid-frame, SHALL force state IDLE and zero every output and register immediately.
REQ-040 After reset, the in-flight frame is abandoned and no o_done is produced for it.

Structure
REQ-041 Package conv_pkg SHALL hold BIT_W=8, PE_IMAGE_W=144, PE_KERNEL_W=144, PE_OUT_W=16, and the FSM state encoding.
REQ-042 Address and counter generation (ox, oy, k, rd_addr) SHALL be one sub-module, conv_addr_gen. The PE itself is instantiated outside conv_ctrl.

Verification
REQ-043 Scenario 1: 4x4 frame, all ch0=0x10, all ch1=0x00; kernel ch0=0x10, ch1=0x00 -> 4 outputs, each o_out_data=0x0090, o_out_addr 0,1,2,3, then one o_done pulse.
REQ-044 Scenario 2: 3x3 frame, pixel value 0x10 at index 4 (ch0), kernel ch0 element 4 = 0x20, all else 0 -> single output 0x0020, rd_addr sequence 0..8.
REQ-045 Scenario 3: hold i_out_ready=0 for 5 cycles in OUT -> data and addr stable, no new o_rd_en, exactly one handshake counted.
REQ-046 Scenario 4: i_start pulsed during LOAD of pixel 1 -> ignored; output count and i_kernel latch unchanged.
REQ-047 Scenario 5: i_rst_n low during WAIT of pixel 2 -> all outputs 0 next evaluation, state IDLE, no o_done; a new i_start runs a full frame correctly.
REQ-048 Scenario 6: 5x4 frame -> rd_addr of the first read of output 4 (ox=1, oy=1) equals 6; 6 outputs total.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl shared package
// datapath widths and FSM state encoding
package conv_pkg;
  localparam int BIT_W       = 8;
  localparam int PE_IMAGE_W  = 144;
  localparam int PE_KERNEL_W = 144;
  localparam int PE_OUT_W    = 16;
  localparam int PIX_W       = 2 * BIT_W;
  localparam int WIN_N       = 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_CALC = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;
endpackage

// File: rtl/conv_ctrl_if.sv
// conv_ctrl SRAM read port and output stream
// master = controller side, slave = memory / sink side
interface conv_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  import conv_pkg::*;

  logic                o_rd_en;
  logic [ADDR_W-1:0]   o_rd_addr;
  logic [PIX_W-1:0]    i_rd_data;
  logic                o_out_valid;
  logic [PE_OUT_W-1:0] o_out_data;
  logic [ADDR_W-1:0]   o_out_addr;
  logic                i_out_ready;

  modport master (
    output o_rd_en, o_rd_addr,
    output o_out_valid, o_out_data, o_out_addr,
    input  i_rd_data, i_out_ready
  );

  modport slave (
    input  o_rd_en, o_rd_addr,
    input  o_out_valid, o_out_data, o_out_addr,
    output i_rd_data, i_out_ready
  );
endinterface

// File: rtl/conv_ctrl_addr_gen.sv
// conv_ctrl window counters and address generation
// ox/oy walk output pixels, k walks the 3x3 window
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic              adv_i,
  output logic [3:0]        k_o,
  output logic              last_k_o,
  output logic              last_px_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] out_idx_o
);
  localparam int CW = 7;

  logic [1:0]    kc_q, kc_d, kr_q, kr_d;
  logic [3:0]    k_q, k_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0] row_a, col_a;

  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kc_q <= '0;
      kr_q <= '0;
      k_q  <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kc_q <= kc_d;
      kr_q <= kr_d;
      k_q  <= k_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  // clear on start, step window per read, advance after handshake
  always_comb begin
    kc_d = kc_q;
    kr_d = kr_q;
    k_d  = k_q;
    ox_d = ox_q;
    oy_d = oy_q;
    unique case (1'b1)
      clr_i: begin
        kc_d = '0;
        kr_d = '0;
        k_d  = '0;
        ox_d = '0;
        oy_d = '0;
      end
      step_i: begin
        k_d = last_k_o ? 4'd0 : k_q + 4'd1;
        if (kc_q == 2'd2) begin
          kc_d = '0;
          kr_d = (kr_q == 2'd2) ? 2'd0 : kr_q + 2'd1;
        end else begin
          kc_d = kc_q + 2'd1;
        end
      end
      adv_i: begin
        if (ox_q == CW'(IMG_W - 3)) begin
          ox_d = '0;
          oy_d = oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // pixel read address and output index
  always_comb begin
    row_a     = ADDR_W'(oy_q) + ADDR_W'(kr_q);
    col_a     = ADDR_W'(ox_q) + ADDR_W'(kc_q);
    rd_addr_o = row_a * ADDR_W'(IMG_W) + col_a;
    out_idx_o = ADDR_W'(oy_q) * ADDR_W'(IMG_W - 2)
              + ADDR_W'(ox_q);
  end

  assign k_o       = k_q;
  assign last_k_o  = (k_q == 4'd8);
  assign last_px_o = (ox_q == CW'(IMG_W - 3))
                  && (oy_q == CW'(IMG_H - 3));
endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: 3x3 two-channel convolution sequencer
// fetches each window from SRAM, feeds PE, streams results
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [PE_KERNEL_W-1:0] i_kernel,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [PE_IMAGE_W-1:0]  o_pe_image,
  output logic [PE_KERNEL_W-1:0] o_pe_kernel,
  input  logic [PE_OUT_W-1:0]    i_pe_result,
  conv_ctrl_if.master            bus
);
  state_t state_q, state_d;

  logic              clr, step, adv, calc;
  logic [3:0]        k, cap_k_q;
  logic              cap_v_q;
  logic              last_k, last_px;
  logic [ADDR_W-1:0] ag_addr, out_idx;

  logic [PE_KERNEL_W-1:0] kern_q;
  logic [PE_IMAGE_W-1:0]  img_q;
  logic [PE_OUT_W-1:0]    od_q;
  logic [ADDR_W-1:0]      oa_q;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_ag (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clr_i    (clr),
    .step_i   (step),
    .adv_i    (adv),
    .k_o      (k),
    .last_k_o (last_k),
    .last_px_o(last_px),
    .rd_addr_o(ag_addr),
    .out_idx_o(out_idx)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_LOAD;
      S_LOAD: if (last_k) state_d = S_WAIT;
      S_WAIT: state_d = S_CALC;
      S_CALC: state_d = S_OUT;
      S_OUT: begin
        if (bus.i_out_ready)
          state_d = last_px ? S_DONE : S_LOAD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs and strobes
  always_comb begin
    o_busy          = (state_q != S_IDLE);
    o_done          = (state_q == S_DONE);
    bus.o_rd_en     = (state_q == S_LOAD);
    bus.o_out_valid = (state_q == S_OUT);
    bus.o_rd_addr   = bus.o_rd_en ? ag_addr : '0;
    clr  = (state_q == S_IDLE) && i_start;
    step = (state_q == S_LOAD);
    calc = (state_q == S_CALC);
    adv  = bus.o_out_valid && bus.i_out_ready;
  end

  // kernel latch, window capture one cycle after each read, result hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      kern_q  <= '0;
      img_q   <= '0;
      cap_v_q <= 1'b0;
      cap_k_q <= '0;
      od_q    <= '0;
      oa_q    <= '0;
    end else begin
      cap_v_q <= step;
      cap_k_q <= k;
      if (clr) kern_q <= i_kernel;
      if (cap_v_q) begin
        for (int i = 0; i < WIN_N; i++) begin
          if (cap_k_q == 4'(i)) begin
            img_q[PE_IMAGE_W-1-BIT_W*i -: BIT_W]
              <= bus.i_rd_data[PIX_W-1 -: BIT_W];
            img_q[PE_IMAGE_W/2-1-BIT_W*i -: BIT_W]
              <= bus.i_rd_data[BIT_W-1:0];
          end
        end
      end
      if (calc) begin
        od_q <= i_pe_result;
        oa_q <= out_idx;
      end
    end
  end

  assign o_pe_image     = img_q;
  assign o_pe_kernel    = kern_q;
  assign bus.o_out_data = od_q;
  assign bus.o_out_addr = oa_q;
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: three frame geometries (4x4, 3x3, 5x4)
// SRAM and PE models, scoreboard of reads and outputs
module tb_conv_ctrl;
  localparam int NI = 3;
  localparam int WS [NI] = '{4, 3, 5};
  localparam int HS [NI] = '{4, 3, 4};

  typedef struct {
    logic [15:0] d;
    int          a;
  } exp_t;

  typedef struct {
    int         inst;
    logic [7:0] p0, p1, k0, k1;
    int         n;
    logic [15:0] d;
  } vec_t;

  logic clk, rst_n, start, ready;
  logic [143:0] kin, kern;
  logic [15:0]  mem [0:255];
  int sel;

  logic         busy_v [NI], done_v [NI];
  logic         rd_en_v [NI], val_v [NI];
  logic [11:0]  rd_addr_v [NI], oaddr_v [NI];
  logic [15:0]  data_v [NI];
  logic [143:0] img_v [NI], ker_v [NI];

  logic         m_busy, m_done, m_rd_en, m_out_valid;
  logic [11:0]  m_rd_addr, m_out_addr;
  logic [15:0]  m_out_data;
  logic [143:0] m_pe_image, m_pe_kernel;

  int checks = 0, errs = 0, cyc = 0;
  int n_done = 0, done0 = 0, n_hs = 0, n_stall = 0;
  int first_rd = -1, first_val = -1, last_hs = -1;
  int hold_left = 0;
  bit stalled = 0, pv_valid = 0, pv_hs = 0, tab_en = 0;
  logic [15:0] pv_d, tab_d;
  logic [11:0] pv_a;
  int   exp_rd [$];
  exp_t exp_out [$];
  int   rd_log [$];

  function automatic logic [15:0] pe_fn(
    input logic [143:0] img, input logic [143:0] ker);
    int s = 0;
    for (int i = 0; i < 18; i++)
      s += int'($signed(img[143-8*i -: 8]))
         * int'($signed(ker[143-8*i -: 8]));
    return 16'(s >>> 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : G
    logic [15:0] rdq, pe_r;
    conv_ctrl_if #(.ADDR_W(12)) bus ();
    always @(posedge clk) rdq <= mem[bus.o_rd_addr[7:0]];
    assign pe_r            = pe_fn(img_v[g], ker_v[g]);
    assign bus.i_rd_data   = rdq;
    assign bus.i_out_ready = ready;
    assign rd_en_v[g]   = bus.o_rd_en;
    assign rd_addr_v[g] = bus.o_rd_addr;
    assign val_v[g]     = bus.o_out_valid;
    assign data_v[g]    = bus.o_out_data;
    assign oaddr_v[g]   = bus.o_out_addr;
    conv_ctrl #(
      .IMG_W(WS[g]), .IMG_H(HS[g]), .ADDR_W(12)
    ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start && (sel == g)),
      .i_kernel   (kin),
      .o_busy     (busy_v[g]),
      .o_done     (done_v[g]),
      .o_pe_image (img_v[g]),
      .o_pe_kernel(ker_v[g]),
      .i_pe_result(pe_r),
      .bus        (bus)
    );
  end

  always_comb begin
    m_busy      = busy_v[sel];
    m_done      = done_v[sel];
    m_rd_en     = rd_en_v[sel];
    m_rd_addr   = rd_addr_v[sel];
    m_out_valid = val_v[sel];
    m_out_data  = data_v[sel];
    m_out_addr  = oaddr_v[sel];
    m_pe_image  = img_v[sel];
    m_pe_kernel = ker_v[sel];
  end

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [143:0] act,
                     input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // downstream ready: low for hold_left valid cycles
  initial begin
    ready = 1;
    forever begin
      @(posedge clk); #1;
      if (hold_left > 0) begin
        ready = 0;
        if (m_out_valid) hold_left--;
      end else ready = 1;
    end
  end

  // monitor: reads, outputs, handshakes, done pulses
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (m_rd_en) begin
        rd_log.push_back(int'(m_rd_addr));
        if (first_rd < 0) first_rd = cyc;
        chk("rd_during_out", m_out_valid, 0);
        if (exp_rd.size() == 0) begin
          checks++; errs++;
          $display("FAIL rd_extra: addr %0d", m_rd_addr);
        end else chk("rd_addr", m_rd_addr, exp_rd.pop_front());
      end
      if (m_out_valid) begin
        if (first_val < 0) first_val = cyc;
        if (pv_valid && !pv_hs) begin
          chk("hold_data", m_out_data, pv_d);
          chk("hold_addr", m_out_addr, pv_a);
        end
        if (ready) begin
          n_hs++;
          if (exp_out.size() == 0) begin
            checks++; errs++;
            $display("FAIL out_extra: addr %0d", m_out_addr);
          end else begin
            e = exp_out.pop_front();
            chk("out_data", m_out_data, e.d);
            chk("out_addr", m_out_addr, e.a);
          end
          if (tab_en) chk("tab_data", m_out_data, tab_d);
          chk("pe_kernel", m_pe_kernel, kern);
          if (last_hs >= 0 && !stalled)
            chk("throughput", cyc - last_hs, 12);
          last_hs = cyc;
          stalled = 0;
        end else begin
          n_stall++;
          stalled = 1;
        end
        pv_valid = 1; pv_hs = ready;
        pv_d = m_out_data; pv_a = m_out_addr;
      end else pv_valid = 0;
      if (m_done) n_done++;
    end
  end

  task automatic push_frame(input int w, input int h);
    logic [143:0] win;
    exp_t e;
    for (int oy = 0; oy < h - 2; oy++)
      for (int ox = 0; ox < w - 2; ox++) begin
        for (int k = 0; k < 9; k++) begin
          int a;
          a = (oy + k / 3) * w + ox + k % 3;
          exp_rd.push_back(a);
          win[143-8*k -: 8] = mem[a][15:8];
          win[71-8*k -: 8]  = mem[a][7:0];
        end
        e.d = pe_fn(win, kern);
        e.a = oy * (w - 2) + ox;
        exp_out.push_back(e);
      end
  endtask

  task automatic fill(input logic [7:0] p0, p1, k0, k1);
    for (int i = 0; i < 256; i++) mem[i] = {p0, p1};
    for (int k = 0; k < 9; k++) begin
      kern[143-8*k -: 8] = k0;
      kern[71-8*k -: 8]  = k1;
    end
  endtask

  task automatic begin_frame(input int inst);
    sel = inst; kin = kern;
    rd_log.delete();
    first_rd = -1; first_val = -1; last_hs = -1;
    stalled = 0; n_stall = 0; n_hs = 0; done0 = n_done;
    push_frame(WS[inst], HS[inst]);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", m_busy, 1);
  endtask

  task automatic finish_frame(input int n);
    int t = 0;
    while (n_done == done0 && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    chk("done_seen", n_done > done0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", n_done - done0, 1);
    chk("out_count", n_hs, n);
    chk("sb_out_left", exp_out.size(), 0);
    chk("sb_rd_left", exp_rd.size(), 0);
    chk("latency", first_val - first_rd, 11);
    chk("idle_busy", m_busy, 0);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_rd_en"}, m_rd_en, 0);
    chk({tag, "_rd_addr"}, m_rd_addr, 0);
    chk({tag, "_valid"}, m_out_valid, 0);
    chk({tag, "_data"}, m_out_data, 0);
    chk({tag, "_oaddr"}, m_out_addr, 0);
    chk({tag, "_image"}, m_pe_image, 0);
    chk({tag, "_kernel"}, m_pe_kernel, 0);
  endtask

  task automatic wait_hs_load(input int n);
    int t = 0;
    while (!(n_hs >= n && m_rd_en) && t < 1000) begin
      @(negedge clk); #1; t++;
    end
    chk("reach_load", m_rd_en, 1);
  endtask

  vec_t vt [4];

  initial begin
    vt[0] = '{0, 8'h10, 8'h00, 8'h10, 8'h00, 4, 16'h0090};
    vt[1] = '{0, 8'h10, 8'h20, 8'h10, 8'h08, 4, 16'h0120};
    vt[2] = '{1, 8'hF0, 8'h00, 8'h10, 8'h00, 1, 16'hFF70};
    vt[3] = '{2, 8'h08, 8'h08, 8'h10, 8'h10, 6, 16'h0090};
    sel = 0; start = 0; kin = '0; kern = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_checks("reset");
    rst_n = 1;

    foreach (vt[i]) begin
      fill(vt[i].p0, vt[i].p1, vt[i].k0, vt[i].k1);
      tab_en = 1; tab_d = vt[i].d;
      begin_frame(vt[i].inst);
      finish_frame(vt[i].n);
    end

    fill(8'h00, 8'h00, 8'h00, 8'h00);
    mem[4] = {8'h10, 8'h00};
    kern[111:104] = 8'h20;
    tab_d = 16'h0020;
    begin_frame(1);
    finish_frame(1);
    for (int i = 0; i < 9; i++)
      chk("rd_seq", rd_log.size() > i ? rd_log[i] : -1, i);
    tab_en = 0;

    fill(8'h10, 8'h00, 8'h10, 8'h00);
    hold_left = 5;
    begin_frame(0);
    finish_frame(4);
    chk("stall_cycles", n_stall, 5);

    fill(8'h10, 8'h20, 8'h10, 8'h08);
    begin_frame(0);
    wait_hs_load(1);
    @(posedge clk); #1 start = 1; kin = ~kern;
    @(posedge clk); #1 start = 0; kin = kern;
    finish_frame(4);

    fill(8'h10, 8'h00, 8'h10, 8'h00);
    begin_frame(0);
    wait_hs_load(2);
    begin
      int t = 0;
      while (m_rd_en && t < 50) begin
        @(negedge clk); #1; t++;
      end
    end
    rst_n = 0;
    #1 rst_checks("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("no_done_after_rst", n_done, done0);
    exp_rd.delete(); exp_out.delete();
    fill(8'h10, 8'h20, 8'h10, 8'h08);
    begin_frame(0);
    finish_frame(4);

    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i * 3), 8'(i + 1)};
    for (int k = 0; k < 9; k++) begin
      kern[143-8*k -: 8] = 8'(k + 1);
      kern[71-8*k -: 8]  = 8'(8'hF0 + k);
    end
    begin_frame(2);
    finish_frame(6);
    chk("rd_first_out4",
        rd_log.size() > 36 ? rd_log[36] : -1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
